// File: rtl/picorv32_uart_pkg.sv
// rtl/picorv32_uart_pkg.sv - register map, status bits and serializer states for the UART console
package picorv32_uart_pkg;

   localparam logic [3:0] OFS_DATA   = 4'h0;
   localparam logic [3:0] OFS_STATUS = 4'h4;
   localparam logic [3:0] OFS_DIV    = 4'h8;
   localparam logic [3:0] OFS_CTRL   = 4'hC;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_LEVEL_LSB = 8;

   localparam logic [15:0] MIN_DIV = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/picorv32_uart_fifo.sv
// rtl/picorv32_uart_fifo.sv - byte-wide synchronous TX FIFO; a full FIFO still accepts a push when popped in the same cycle
module picorv32_uart_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [7:0]  din,
   input  logic        pop,
   output logic [7:0]  dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push != do_pop) level <= do_push ? level + 1'b1 : level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/picorv32_uart_console.sv
// rtl/picorv32_uart_console.sv - memory-mapped 8N1 UART TX console on the picorv32 mem bus
// Optional CONSOLE_IRQ_EN adds CTRL.irq_en and the irq_tx drain interrupt.
module picorv32_uart_console
   import picorv32_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        sel_ready,
   output logic [31:0] sel_rdata,
   output logic        uart_tx
`ifdef CONSOLE_IRQ_EN
   ,
   output logic        irq_tx
`endif
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [LW-1:0] fifo_level;
   logic          fifo_pop;
   logic          fifo_push;

   logic [15:0] div;
   logic        hit;
   logic        is_wr;
   logic [3:0]  ofs;
   logic        data_wr;
   logic        accept;
   logic [31:0] rdata_n;
   logic [15:0] div_wval;
   logic        tx_busy;
   logic        irq_en;

   tx_state_t   state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [15:0] bit_div, bit_div_n;
   logic [7:0]  shreg, shreg_n;
   logic [2:0]  bit_idx, bit_n;
   logic        tx_q, tx_n;

   picorv32_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (mem_wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // A DATA write into a full FIFO is held off unless the serializer frees a slot this cycle.
   assign hit       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !sel_ready;
   assign is_wr     = |mem_wstrb;
   assign ofs       = {mem_addr[3:2], 2'b00};
   assign data_wr   = hit && is_wr && (ofs == OFS_DATA) && mem_wstrb[0];
   assign accept    = hit && !(data_wr && fifo_full && !fifo_pop);
   assign fifo_push = accept && data_wr;
   assign tx_busy   = (state != ST_IDLE);
   assign uart_tx   = tx_q;
   assign div_wval  = {mem_wstrb[1] ? mem_wdata[15:8] : div[15:8],
                       mem_wstrb[0] ? mem_wdata[7:0]  : div[7:0]};

   always_comb begin
      rdata_n = '0;
      if (!is_wr) begin
         case (ofs)
            OFS_STATUS: begin
               rdata_n[STAT_BUSY]  = tx_busy;
               rdata_n[STAT_FULL]  = fifo_full;
               rdata_n[STAT_EMPTY] = fifo_empty;
               rdata_n[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
            end
            OFS_DIV:  rdata_n[15:0] = div;
            OFS_CTRL: rdata_n[0] = irq_en;
            default:  rdata_n = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_ready <= 1'b0;
         sel_rdata <= '0;
         div       <= DEFAULT_DIV;
      end else begin
         sel_ready <= accept;
         sel_rdata <= accept ? rdata_n : '0;
         if (accept && is_wr && (ofs == OFS_DIV) && (|mem_wstrb[1:0]))
            div <= clamp_div(div_wval);
      end
   end

`ifdef CONSOLE_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en <= 1'b0;
         irq_tx <= 1'b0;
      end else begin
         if (accept && (ofs == OFS_CTRL) && mem_wstrb[0]) irq_en <= mem_wdata[0];
         irq_tx <= irq_en && fifo_empty && !tx_busy;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_div <= MIN_DIV;
         shreg   <= '0;
         bit_idx <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_div <= bit_div_n;
         shreg   <= shreg_n;
         bit_idx <= bit_n;
         tx_q    <= tx_n;
      end
   end

   // The last stop-bit cycle is spent in IDLE, so a waiting byte starts with no gap.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_div_n = bit_div;
      shreg_n   = shreg;
      bit_n     = bit_idx;
      tx_n      = tx_q;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shreg_n   = fifo_dout;
               bit_div_n = div;
               cnt_n     = div - 16'd1;
               tx_n      = 1'b0;
               state_n   = ST_START;
            end
         end
         ST_START: begin
            if (cnt == '0) begin
               cnt_n   = bit_div - 16'd1;
               bit_n   = '0;
               tx_n    = shreg[0];
               state_n = ST_DATA;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt == '0) begin
               cnt_n = bit_div - 16'd1;
               if (bit_idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = ST_STOP;
               end else begin
                  shreg_n = shreg >> 1;
                  tx_n    = shreg[1];
                  bit_n   = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         ST_STOP: begin
            if (cnt == 16'd1) state_n = ST_IDLE;
            else              cnt_n   = cnt - 16'd1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule
